uart_tag_decoder: RTL and testbench

Demultiplexing stage between the host-link UART receive FIFO and the per-channel UART transmit FIFOs. It pops bytes from the host RX FIFO and parses an in-band escape protocol that selects the target channel. Payload bytes are written to the selected channel's TX FIFO, and back-pressure is honoured. One instance serves all `UART_COUNT` downstream UARTs.

---
 rtl/uart_tag_decoder.sv | 154 +++++++++++++++
 tb/tb_uart_tag_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tag_decoder.sv
// Host-link demultiplexer: parses ESC-tagged byte stream and steers payload to per-channel TX FIFOs.
// Optional build macro UART_TAG_DROP_EN: discard (and count) bytes aimed at a full channel instead of stalling.
module uart_tag_decoder #(
    parameter int                   DATA_BITS  = 8,
    parameter int                   UART_COUNT = 4,
    parameter logic [DATA_BITS-1:0] ESC_BYTE   = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            fifo_empty,
    input  logic [DATA_BITS-1:0]            fifo_data,
    output logic                            fifo_read,
    input  logic [UART_COUNT-1:0]           full,
    output logic [UART_COUNT-1:0]           write,
    output logic [DATA_BITS*UART_COUNT-1:0] data,
    output logic [3:0]                      channel,
    output logic [7:0]                      err_count
);

    localparam logic [DATA_BITS-1:0] CHAN_LIMIT = DATA_BITS'(UART_COUNT);

    typedef enum logic [0:0] {
        S_DATA = 1'b0,
        S_ESC  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  channel_r;
    logic [7:0]  err_count_r;
    logic        target_full_s;
    logic        wr_en_s;
    logic        pop_s;
    logic        chan_load_s;
    logic        err_inc_s;
    logic        head_valid_s;
    logic        head_is_esc_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value != 8'hFF) begin
            sat_inc8 = value + 8'd1;
        end else begin
            sat_inc8 = value;
        end
    endfunction

    // Full flag of the currently selected channel.
    always_comb begin
        target_full_s = 1'b0;
        for (int i = 0; i < UART_COUNT; i++) begin
            target_full_s = target_full_s | (full[i] & (channel_r == 4'(i)));
        end
    end

    // A pop never happens while in reset, so a pending escape or stalled byte is preserved in the FIFO.
    assign head_valid_s  = ~fifo_empty & ~reset;
    assign head_is_esc_s = (fifo_data == ESC_BYTE);

    // Next-state and pop/write decision from the protocol state and the FIFO head.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        wr_en_s      = 1'b0;
        chan_load_s  = 1'b0;
        err_inc_s    = 1'b0;
        case (state_r)
            S_DATA: begin
                if (!head_valid_s) begin
                    state_next_s = S_DATA;
                end else if (head_is_esc_s) begin
                    pop_s        = 1'b1;
                    state_next_s = S_ESC;
                end else if (!target_full_s) begin
                    pop_s   = 1'b1;
                    wr_en_s = 1'b1;
                end else begin
`ifdef UART_TAG_DROP_EN
                    pop_s     = 1'b1;
                    err_inc_s = 1'b1;
`else
                    pop_s     = 1'b0;
`endif
                end
            end
            S_ESC: begin
                if (!head_valid_s) begin
                    state_next_s = S_ESC;
                end else if (head_is_esc_s) begin
                    // Escaped literal: same back-pressure handling as plain payload.
                    if (!target_full_s) begin
                        pop_s        = 1'b1;
                        wr_en_s      = 1'b1;
                        state_next_s = S_DATA;
                    end else begin
`ifdef UART_TAG_DROP_EN
                        pop_s        = 1'b1;
                        err_inc_s    = 1'b1;
                        state_next_s = S_DATA;
`else
                        state_next_s = S_ESC;
`endif
                    end
                end else if (fifo_data < CHAN_LIMIT) begin
                    pop_s        = 1'b1;
                    chan_load_s  = 1'b1;
                    state_next_s = S_DATA;
                end else begin
                    pop_s        = 1'b1;
                    err_inc_s    = 1'b1;
                    state_next_s = S_DATA;
                end
            end
            default: begin
                state_next_s = S_DATA;
            end
        endcase
    end

    // Protocol state, selected channel and error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_DATA;
            channel_r   <= 4'd0;
            err_count_r <= 8'd0;
        end else begin
            state_r <= state_next_s;
            if (chan_load_s) begin
                channel_r <= fifo_data[3:0];
            end else begin
                channel_r <= channel_r;
            end
            if (err_inc_s) begin
                err_count_r <= sat_inc8(err_count_r);
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    // Write strobe decode and head-byte fan-out to every lane.
    always_comb begin
        write = '0;
        data  = '0;
        for (int i = 0; i < UART_COUNT; i++) begin
            write[i]                          = wr_en_s & (channel_r == 4'(i));
            data[i*DATA_BITS +: DATA_BITS]    = fifo_data;
        end
    end

    assign fifo_read = pop_s;
    assign channel   = channel_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_uart_tag_decoder.sv
// Self-checking bench for uart_tag_decoder: directed protocol cases plus randomized traffic against a protocol-level model.
module tb_uart_tag_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_read;
    logic [3:0]  full;
    logic [3:0]  write;
    logic [31:0] data;
    logic [3:0]  channel;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       m_pend;
    logic [3:0] m_ch;
    int         m_err;
    logic       exp_read;
    logic [3:0] exp_write;
    logic       exp_err;
    logic       exp_sel;
    logic       exp_pend_next;

    always #5 clk = ~clk;

    uart_tag_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .full       (full),
        .write      (write),
        .data       (data),
        .channel    (channel),
        .err_count  (err_count)
    );

    // Drive one cycle's inputs from the host queue and predict the protocol outcome; leaves time at the negedge.
    task automatic prep(input logic rst, input logic [3:0] f);
        reset         = rst;
        full          = f;
        fifo_empty    = (q.size() == 0);
        fifo_data     = (q.size() != 0) ? q[0] : 8'($urandom);
        exp_read      = 1'b0;
        exp_write     = 4'b0000;
        exp_err       = 1'b0;
        exp_sel       = 1'b0;
        exp_pend_next = m_pend;
        if (!rst && q.size() != 0) begin
            if (!m_pend && q[0] == 8'hFF) begin
                exp_read = 1'b1; exp_pend_next = 1'b1;
            end else if (m_pend && q[0] < 8'd4) begin
                exp_read = 1'b1; exp_sel = 1'b1; exp_pend_next = 1'b0;
            end else if (m_pend && q[0] != 8'hFF) begin
                exp_read = 1'b1; exp_err = 1'b1; exp_pend_next = 1'b0;
            end else if (!f[m_ch]) begin
                exp_read = 1'b1; exp_write = 4'b0001 << m_ch; exp_pend_next = 1'b0;
            end else begin
`ifdef UART_TAG_DROP_EN
                exp_read = 1'b1; exp_err = 1'b1; exp_pend_next = 1'b0;
`else
                exp_read = 1'b0;
`endif
            end
        end
        @(negedge clk);
    endtask

    // Clock edge: commit the model's view of the consumed byte.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_pend = 1'b0; m_ch = 4'd0; m_err = 0;
        end else begin
            if (exp_sel) m_ch = q[0][3:0];
            if (exp_err && m_err < 255) m_err++;
            m_pend = exp_pend_next;
            if (exp_read) void'(q.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        q.push_back(8'hFF);
        for (int i = 0; i < 2; i++) begin
            prep(1'b1, 4'b0000);
            checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", fifo_read); end
            checks++; if (write !== 4'b0000) begin errors++; $display("FAIL reset_write got %b want 0000", write); end
            advance();
        end
        checks++; if (channel !== 4'd0) begin errors++; $display("FAIL reset_channel got %0d want 0", channel); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
        q.delete();
        prep(1'b0, 4'b0000);
        advance();
    endtask

    task automatic test_payload();
        q.push_back(8'h41); q.push_back(8'h42);
        prep(1'b0, 4'b0000);
        checks++; if (write !== 4'b0001) begin errors++; $display("FAIL payload_w0 got %b want 0001", write); end
        checks++; if (data[7:0] !== 8'h41) begin errors++; $display("FAIL payload_d0 got %h want 41", data[7:0]); end
        checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL payload_r0 got %b want 1", fifo_read); end
        advance();
        prep(1'b0, 4'b0000);
        checks++; if (write !== 4'b0001) begin errors++; $display("FAIL payload_w1 got %b want 0001", write); end
        checks++; if (data[7:0] !== 8'h42) begin errors++; $display("FAIL payload_d1 got %h want 42", data[7:0]); end
        advance();
        checks++; if (channel !== 4'd0) begin errors++; $display("FAIL payload_ch got %0d want 0", channel); end
    endtask

    task automatic test_select();
        q.push_back(8'hFF); q.push_back(8'h02); q.push_back(8'h55);
        for (int i = 0; i < 2; i++) begin
            prep(1'b0, 4'b0000);
            checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL select_pop%0d got %b want 1", i, fifo_read); end
            checks++; if (write !== 4'b0000) begin errors++; $display("FAIL select_nowr%0d got %b want 0000", i, write); end
            advance();
        end
        checks++; if (channel !== 4'd2) begin errors++; $display("FAIL select_ch got %0d want 2", channel); end
        prep(1'b0, 4'b0000);
        checks++; if (write !== 4'b0100) begin errors++; $display("FAIL select_w got %b want 0100", write); end
        checks++; if (data[23:16] !== 8'h55) begin errors++; $display("FAIL select_d got %h want 55", data[23:16]); end
        advance();
    endtask

    task automatic test_literal();
        q.push_back(8'hFF); q.push_back(8'h01); q.push_back(8'hFF); q.push_back(8'hFF);
        prep(1'b0, 4'b0000); advance();
        prep(1'b0, 4'b0000); advance();
        checks++; if (channel !== 4'd1) begin errors++; $display("FAIL literal_ch got %0d want 1", channel); end
        prep(1'b0, 4'b0000);
        checks++; if (fifo_read !== 1'b1 || write !== 4'b0000) begin errors++; $display("FAIL literal_esc got r=%b w=%b want r=1 w=0000", fifo_read, write); end
        advance();
        prep(1'b0, 4'b0000);
        checks++; if (write !== 4'b0010) begin errors++; $display("FAIL literal_w got %b want 0010", write); end
        checks++; if (data[15:8] !== 8'hFF) begin errors++; $display("FAIL literal_d got %h want ff", data[15:8]); end
        advance();
        prep(1'b0, 4'b0000);
        checks++; if (write !== 4'b0000) begin errors++; $display("FAIL literal_single got %b want 0000", write); end
        advance();
    endtask

    task automatic test_error();
        q.push_back(8'hFF); q.push_back(8'h07);
        prep(1'b0, 4'b0000); advance();
        prep(1'b0, 4'b0000);
        checks++; if (fifo_read !== 1'b1 || write !== 4'b0000) begin errors++; $display("FAIL error_pop got r=%b w=%b want r=1 w=0000", fifo_read, write); end
        advance();
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL error_cnt got %0d want 1", err_count); end
        checks++; if (channel !== 4'd1) begin errors++; $display("FAIL error_ch got %0d want 1", channel); end
    endtask

    task automatic test_stall();
        q.push_back(8'hFF); q.push_back(8'h00);
        prep(1'b0, 4'b0000); advance();
        prep(1'b0, 4'b0000); advance();
        q.push_back(8'h33);
        for (int i = 0; i < 5; i++) begin
            prep(1'b0, 4'b0001);
`ifdef UART_TAG_DROP_EN
            if (i == 0) begin
                checks++; if (fifo_read !== 1'b1 || write !== 4'b0000) begin errors++; $display("FAIL drop_pop got r=%b w=%b want r=1 w=0000", fifo_read, write); end
            end else begin
                checks++; if (fifo_read !== 1'b0 || write !== 4'b0000) begin errors++; $display("FAIL drop_idle%0d got r=%b w=%b want r=0 w=0000", i, fifo_read, write); end
            end
`else
            checks++; if (fifo_read !== 1'b0 || write !== 4'b0000) begin errors++; $display("FAIL stall%0d got r=%b w=%b want r=0 w=0000", i, fifo_read, write); end
`endif
            advance();
        end
        prep(1'b0, 4'b0000);
`ifdef UART_TAG_DROP_EN
        checks++; if (write !== 4'b0000) begin errors++; $display("FAIL drop_nowr got %b want 0000", write); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL drop_cnt got %0d want 2", err_count); end
`else
        checks++; if (write !== 4'b0001 || data[7:0] !== 8'h33) begin errors++; $display("FAIL stall_release got w=%b d=%h want w=0001 d=33", write, data[7:0]); end
`endif
        advance();
    endtask

    task automatic test_reset_mid_esc();
        q.push_back(8'hFF); q.push_back(8'h03);
        prep(1'b0, 4'b0000); advance();
        prep(1'b0, 4'b0000); advance();
        q.push_back(8'hFF);
        prep(1'b0, 4'b0000); advance();
        q.push_back(8'h10);
        prep(1'b1, 4'b0000);
        checks++; if (fifo_read !== 1'b0 || write !== 4'b0000) begin errors++; $display("FAIL rstesc_hold got r=%b w=%b want r=0 w=0000", fifo_read, write); end
        advance();
        prep(1'b0, 4'b0000);
        checks++; if (write !== 4'b0001 || data[7:0] !== 8'h10) begin errors++; $display("FAIL rstesc_wr got w=%b d=%h want w=0001 d=10", write, data[7:0]); end
        advance();
        checks++; if (err_count !== 8'd0 || channel !== 4'd0) begin errors++; $display("FAIL rstesc_state got err=%0d ch=%0d want 0 0", err_count, channel); end
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 260; i++) begin
            q.push_back(8'hFF); q.push_back(8'($urandom_range(4, 254)));
        end
        for (int i = 0; i < 520; i++) begin
            prep(1'b0, 4'b0000); advance();
            if (i == 509) begin
                checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", err_count); end
            end
        end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", err_count); end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 3000; c++) begin
            if (q.size() < 16 && $urandom_range(0, 9) < 7) begin
                r = $urandom_range(0, 9);
                if (r < 2) q.push_back(8'hFF);
                else if (r < 5) q.push_back(8'($urandom_range(0, 5)));
                else q.push_back(8'($urandom));
            end
            prep(($urandom_range(0, 199) == 0), 4'(($urandom & $urandom) & 32'hF));
            checks++; if (fifo_read !== exp_read) begin errors++; $display("FAIL rand_read c%0d got %b want %b", c, fifo_read, exp_read); end
            checks++; if (write !== exp_write) begin errors++; $display("FAIL rand_write c%0d got %b want %b", c, write, exp_write); end
            checks++; if (data !== {4{fifo_data}}) begin errors++; $display("FAIL rand_data c%0d got %h want %h", c, data, {4{fifo_data}}); end
            checks++; if (channel !== m_ch) begin errors++; $display("FAIL rand_ch c%0d got %0d want %0d", c, channel, m_ch); end
            checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL rand_err c%0d got %0d want %0d", c, err_count, m_err); end
            advance();
        end
    endtask

    initial begin
        m_pend = 1'b0; m_ch = 4'd0; m_err = 0;
        reset = 1'b1; full = 4'b0000; fifo_empty = 1'b1; fifo_data = 8'h00;
        #1;
        test_reset();
        test_payload();
        test_select();
        test_literal();
        test_error();
        test_stall();
        test_reset_mid_esc();
        test_err_saturation();
        prep(1'b1, 4'b0000); advance();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
